// File: rtl/demux_dispatch_ctrl.sv
// 1-to-4 dispatch controller: one valid/ready input stream feeds four
// one-entry output slots, either round-robin or directed by sel.
module demux_dispatch_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       sel,
    input  logic [3:0]       chan_en,
    output logic [W-1:0]     dout0,
    output logic [W-1:0]     dout1,
    output logic [W-1:0]     dout2,
    output logic [W-1:0]     dout3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

    slot_state_e      state_q [4];
    slot_state_e      state_d [4];
    logic [W-1:0]     data_q  [4];
    logic [W-1:0]     data_d  [4];
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [3:0] slot_free;
    logic [3:0] drain;
    logic [3:0] fill;
    logic [1:0] target;
    logic [1:0] cand;
    logic       target_ok;
    logic       drop;
    logic       accept;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        target    = rr_ptr_q;
        target_ok = 1'b0;
        drop      = 1'b0;
        cand      = '0;
        for (int n = 0; n < 4; n++) begin
            drain[n]     = (state_q[n] == FULL) && out_ready[n];
            slot_free[n] = (state_q[n] == EMPTY) || out_ready[n];
        end
        if (mode) begin
            target = sel;
            if (chan_en[sel]) begin
                target_ok = slot_free[sel];
            end else begin
                target_ok = 1'b1;
                drop      = 1'b1;
            end
        end else begin
            // Walk from the farthest offset back so the nearest eligible channel wins.
            for (int i = 3; i >= 0; i--) begin
                cand = rr_ptr_q + 2'(i);
                if (chan_en[cand] && slot_free[cand]) begin
                    target    = cand;
                    target_ok = 1'b1;
                end
            end
        end
        in_ready = target_ok;
        accept   = in_valid && target_ok;
        for (int n = 0; n < 4; n++) begin
            fill[n] = accept && !drop && (target == 2'(n));
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        drop_cnt_d = drop_cnt_q;
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            data_d[n]  = data_q[n];
            if (fill[n]) begin
                state_d[n] = FULL;
                data_d[n]  = din;
            end else if (drain[n]) begin
                state_d[n] = EMPTY;
            end
        end
        if (accept && !mode) begin
            rr_ptr_d = target + 2'd1;
        end
        if (accept && drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= EMPTY;
                data_q[n]  <= '0;
            end
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                data_q[n]  <= data_d[n];
            end
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            out_valid[n] = (state_q[n] == FULL);
        end
    end

    assign dout0    = out_valid[0] ? data_q[0] : '0;
    assign dout1    = out_valid[1] ? data_q[1] : '0;
    assign dout2    = out_valid[2] ? data_q[2] : '0;
    assign dout3    = out_valid[3] ? data_q[3] : '0;
    assign rr_ptr   = rr_ptr_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: table of vectors plus
// hand sequences; per-channel scoreboard queues hold expected slot contents.
module tb_demux_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] chan_en;
    logic [7:0] dout0, dout1, dout2, dout3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] rr_ptr;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [4][$];

    demux_dispatch_ctrl #(.W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .chan_en(chan_en),
        .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .out_valid(out_valid), .out_ready(out_ready),
        .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] en;
        logic [3:0] ordy;
        logic       v;
        logic [7:0] din;
        logic       exp_ready;
        logic [1:0] exp_ch;
        logic       exp_drop;
        logic [1:0] exp_ptr;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] dout_of(input int n);
        case (n)
            0:       return dout0;
            1:       return dout1;
            2:       return dout2;
            default: return dout3;
        endcase
    endfunction

    task automatic check_slots();
        for (int n = 0; n < 4; n++) begin
            check($sformatf("out_valid[%0d]", n), 32'(out_valid[n]), 32'(exp_q[n].size() != 0));
            if (exp_q[n].size() != 0)
                check($sformatf("dout%0d", n), 32'(dout_of(n)), 32'(exp_q[n][0]));
            else
                check($sformatf("dout%0d idle", n), 32'(dout_of(n)), 32'h0);
        end
    endtask

    // Drive one cycle: check in_ready, retire drained words, queue the accepted one.
    task automatic step(input logic v, input logic [7:0] d, input logic exp_ready,
                        input logic [1:0] exp_ch, input logic exp_drop);
        in_valid = v;
        din      = d;
        #1;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        for (int n = 0; n < 4; n++) begin
            if (exp_q[n].size() != 0 && out_ready[n]) begin
                check($sformatf("drain dout%0d", n), 32'(dout_of(n)), 32'(exp_q[n][0]));
                void'(exp_q[n].pop_front());
            end
        end
        if (v && exp_ready && !exp_drop) exp_q[exp_ch].push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_slots();
    endtask

    task automatic clear_model();
        for (int n = 0; n < 4; n++) exp_q[n].delete();
    endtask

    task automatic check_reset_state();
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst dout0", 32'(dout0), 32'h0);
        check("rst dout1", 32'(dout1), 32'h0);
        check("rst dout2", 32'(dout2), 32'h0);
        check("rst dout3", 32'(dout3), 32'h0);
        check("rst rr_ptr", 32'(rr_ptr), 32'h0);
        check("rst drop_cnt", 32'(drop_cnt), 32'h0);
    endtask

    initial begin
        //        mode sel  en       ordy     v   din    rdy  ch  drop ptr  cnt
        vecs[0]  = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h11, 1'b1, 2'd0, 1'b0, 2'd1, 8'd0};
        vecs[1]  = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h22, 1'b1, 2'd1, 1'b0, 2'd2, 8'd0};
        vecs[2]  = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h33, 1'b1, 2'd2, 1'b0, 2'd3, 8'd0};
        vecs[3]  = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h44, 1'b1, 2'd3, 1'b0, 2'd0, 8'd0};
        vecs[4]  = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h55, 1'b1, 2'd0, 1'b0, 2'd1, 8'd0};
        vecs[5]  = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 2'd1, 8'd0};
        // Slot 1 parked with 0xAA, pointer walked back round to 1, then 0xBB skips it.
        vecs[6]  = '{1'b0, 2'd0, 4'hF, 4'hD, 1'b1, 8'hAA, 1'b1, 2'd1, 1'b0, 2'd2, 8'd0};
        vecs[7]  = '{1'b0, 2'd0, 4'hF, 4'hD, 1'b1, 8'h02, 1'b1, 2'd2, 1'b0, 2'd3, 8'd0};
        vecs[8]  = '{1'b0, 2'd0, 4'hF, 4'hD, 1'b1, 8'h03, 1'b1, 2'd3, 1'b0, 2'd0, 8'd0};
        vecs[9]  = '{1'b0, 2'd0, 4'hF, 4'hD, 1'b1, 8'h00, 1'b1, 2'd0, 1'b0, 2'd1, 8'd0};
        vecs[10] = '{1'b0, 2'd0, 4'hF, 4'hD, 1'b1, 8'hBB, 1'b1, 2'd2, 1'b0, 2'd3, 8'd0};
        vecs[11] = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 2'd3, 8'd0};
        // Mode switch with the pointer at 2.
        vecs[12] = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h30, 1'b1, 2'd3, 1'b0, 2'd0, 8'd0};
        vecs[13] = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h31, 1'b1, 2'd0, 1'b0, 2'd1, 8'd0};
        vecs[14] = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h32, 1'b1, 2'd1, 1'b0, 2'd2, 8'd0};
        vecs[15] = '{1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 8'h60, 1'b1, 2'd0, 1'b0, 2'd2, 8'd0};
        vecs[16] = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b1, 8'h61, 1'b1, 2'd2, 1'b0, 2'd3, 8'd0};
        vecs[17] = '{1'b0, 2'd0, 4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 2'd3, 8'd0};
        // Directed stall on full slot 2, then same-cycle drain and fill.
        vecs[18] = '{1'b1, 2'd2, 4'hF, 4'hB, 1'b1, 8'hC0, 1'b1, 2'd2, 1'b0, 2'd3, 8'd0};
        vecs[19] = '{1'b1, 2'd2, 4'hF, 4'hB, 1'b1, 8'hC1, 1'b0, 2'd2, 1'b0, 2'd3, 8'd0};
        vecs[20] = '{1'b1, 2'd2, 4'hF, 4'hF, 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0, 2'd3, 8'd0};
        vecs[21] = '{1'b1, 2'd2, 4'hF, 4'hF, 1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd3, 8'd0};
        // No enabled channel in round-robin; disabled slot still drains.
        vecs[22] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 8'hEE, 1'b0, 2'd0, 1'b0, 2'd3, 8'd0};
        vecs[23] = '{1'b1, 2'd1, 4'hF, 4'h0, 1'b1, 8'hD1, 1'b1, 2'd1, 1'b0, 2'd3, 8'd0};
        vecs[24] = '{1'b0, 2'd0, 4'h0, 4'h2, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd3, 8'd0};
        vecs[25] = '{1'b1, 2'd3, 4'h7, 4'hF, 1'b1, 8'h99, 1'b1, 2'd3, 1'b1, 2'd3, 8'd1};

        rst = 1'b1; in_valid = 1'b0; din = '0; mode = 1'b0; sel = '0;
        chan_en = 4'hF; out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();

        for (int i = 0; i < 26; i++) begin
            mode = vecs[i].mode; sel = vecs[i].sel;
            chan_en = vecs[i].en; out_ready = vecs[i].ordy;
            step(vecs[i].v, vecs[i].din, vecs[i].exp_ready, vecs[i].exp_ch, vecs[i].exp_drop);
            check($sformatf("vec%0d rr_ptr", i), 32'(rr_ptr), 32'(vecs[i].exp_ptr));
            check($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].exp_cnt));
        end

        // 299 more drops to disabled channel 3: counter saturates at 255.
        mode = 1'b1; sel = 2'd3; chan_en = 4'h7; out_ready = 4'hF;
        for (int i = 1; i < 300; i++) begin
            step(1'b1, 8'(i), 1'b1, 2'd3, 1'b1);
            if (i == 99) check("drop_cnt at 100", 32'(drop_cnt), 32'd100);
        end
        check("drop_cnt saturated", 32'(drop_cnt), 32'd255);
        check("rr_ptr after drops", 32'(rr_ptr), 32'd3);

        // Fill all four slots with no consumer, fifth word stalls.
        mode = 1'b0; chan_en = 4'hF; out_ready = 4'h0;
        step(1'b1, 8'hF0, 1'b1, 2'd3, 1'b0);
        step(1'b1, 8'hF1, 1'b1, 2'd0, 1'b0);
        step(1'b1, 8'hF2, 1'b1, 2'd1, 1'b0);
        step(1'b1, 8'hF3, 1'b1, 2'd2, 1'b0);
        check("rr_ptr after fill", 32'(rr_ptr), 32'd3);
        step(1'b1, 8'hF4, 1'b0, 2'd0, 1'b0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        check_reset_state();
        check("in_ready after rst", 32'(in_ready), 32'd1);

        // A word handshaken while rst is high is discarded.
        out_ready = 4'hF;
        rst = 1'b1; in_valid = 1'b1; din = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        check_reset_state();

        step(1'b1, 8'h5A, 1'b1, 2'd0, 1'b0);
        check("rr_ptr post-rst word", 32'(rr_ptr), 32'd1);
        step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
